// File: rtl/tx_fire_capture_if.sv
// Receive-FIFO write port bundle between the transmit/capture sequencer (master) and the
// A/B receive FIFOs (slave).
interface tx_fire_capture_if #(
  parameter int WIDTH = 3
);
  logic             write_en_fifo_A;
  logic             write_en_fifo_B;
  logic [WIDTH-1:0] write_data_fifo_A;
  logic [WIDTH-1:0] write_data_fifo_B;
  logic             fifo_A_full;
  logic             fifo_B_full;

  modport master (
    output write_en_fifo_A, write_en_fifo_B, write_data_fifo_A, write_data_fifo_B,
    input  fifo_A_full, fifo_B_full
  );

  modport slave (
    input  write_en_fifo_A, write_en_fifo_B, write_data_fifo_A, write_data_fifo_B,
    output fifo_A_full, fifo_B_full
  );
endinterface

// File: rtl/tx_fire_capture.sv
// Per scan line: fire delayed A/B transmit pulses, then stream DEPTH ADC echo samples per channel
// into the receive FIFOs. Optional macro CAPTURE_BLANK_EN inserts a ringdown gap before capture.
module tx_fire_capture #(
  parameter int DEPTH        = 16,
  parameter int PTR_LEN      = 4,
  parameter int WIDTH        = 3,
  parameter int SCAN_LINES   = 2,
  parameter int DELAY_W      = 4,
  parameter int PULSE_LEN    = 4,
  parameter int BLANK_CYCLES = 3
) (
  input  logic               Clk,
  input  logic               reset,
  input  logic               start,
  input  logic [DELAY_W-1:0] delay_A,
  input  logic [DELAY_W-1:0] delay_B,
  input  logic [WIDTH-1:0]   adc_A,
  input  logic [WIDTH-1:0]   adc_B,
  output logic [PTR_LEN-1:0] scan_line,
  output logic               tx_pulse_A,
  output logic               tx_pulse_B,
  output logic               busy,
  output logic               done,
  output logic               overflow,
  tx_fire_capture_if.master  fifo
);

`ifdef CAPTURE_BLANK_EN
  localparam bit BLANK_EN = 1'b1;
`else
  localparam bit BLANK_EN = 1'b0;
`endif

  // Fire-phase counter must reach max(dA,dB)+PULSE_LEN-1 without wrapping.
  localparam int TW = $clog2((2 ** DELAY_W) + PULSE_LEN);

  typedef enum logic [2:0] {IDLE, FIRE, BLANK, CAPTURE, NEXT, DONE} state_t;

  state_t               state, state_nxt;
  logic [TW-1:0]        t, t_nxt;
  logic [PTR_LEN-1:0]   c, c_nxt;
  logic [PTR_LEN-1:0]   line_nxt;
  logic                 latch;
  logic [DELAY_W-1:0]   dly_a, dly_b;
  logic [DELAY_W-1:0]   dly_a_nxt, dly_b_nxt;
  logic [TW-1:0]        fire_last;
  logic                 ovf_nxt;

  function automatic logic in_window(input logic [TW-1:0] tt, input logic [DELAY_W-1:0] d);
    logic [TW-1:0] lo;
    lo = TW'(d);
    return (tt >= lo) && (tt <= lo + TW'(PULSE_LEN - 1));
  endfunction

  assign fire_last = ((dly_a >= dly_b) ? TW'(dly_a) : TW'(dly_b)) + TW'(PULSE_LEN - 1);
  assign dly_a_nxt = latch ? delay_A : dly_a;
  assign dly_b_nxt = latch ? delay_B : dly_b;

  always_comb begin
    state_nxt = state;
    t_nxt     = t;
    c_nxt     = c;
    line_nxt  = scan_line;
    latch     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = FIRE;
          t_nxt     = '0;
          line_nxt  = '0;
          latch     = 1'b1;
        end
      end
      FIRE: begin
        if (t == fire_last) begin
          t_nxt = '0;
          c_nxt = '0;
          if (BLANK_EN) state_nxt = BLANK;
          else          state_nxt = CAPTURE;
        end else begin
          t_nxt = t + TW'(1);
        end
      end
      BLANK: begin
        if (t == TW'(BLANK_CYCLES - 1)) begin
          state_nxt = CAPTURE;
          c_nxt     = '0;
        end else begin
          t_nxt = t + TW'(1);
        end
      end
      CAPTURE: begin
        if (c == PTR_LEN'(DEPTH - 1)) state_nxt = NEXT;
        else                          c_nxt     = c + PTR_LEN'(1);
      end
      NEXT: begin
        if (scan_line == PTR_LEN'(SCAN_LINES - 1)) begin
          state_nxt = DONE;
        end else begin
          state_nxt = FIRE;
          line_nxt  = scan_line + PTR_LEN'(1);
          t_nxt     = '0;
          latch     = 1'b1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A full FIFO never stalls capture; the sample is simply lost and flagged.
  always_comb begin
    ovf_nxt = overflow;
    if (state == IDLE && start)
      ovf_nxt = 1'b0;
    else if (state_nxt == CAPTURE && (fifo.fifo_A_full || fifo.fifo_B_full))
      ovf_nxt = 1'b1;
  end

  always_ff @(posedge Clk) begin
    if (latch) begin
      dly_a <= delay_A;
      dly_b <= delay_B;
    end
  end

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      state                  <= IDLE;
      t                      <= '0;
      c                      <= '0;
      scan_line              <= '0;
      tx_pulse_A             <= 1'b0;
      tx_pulse_B             <= 1'b0;
      busy                   <= 1'b0;
      done                   <= 1'b0;
      overflow               <= 1'b0;
      fifo.write_en_fifo_A   <= 1'b0;
      fifo.write_en_fifo_B   <= 1'b0;
      fifo.write_data_fifo_A <= '0;
      fifo.write_data_fifo_B <= '0;
    end else begin
      state                  <= state_nxt;
      t                      <= t_nxt;
      c                      <= c_nxt;
      scan_line              <= line_nxt;
      tx_pulse_A             <= (state_nxt == FIRE) && in_window(t_nxt, dly_a_nxt);
      tx_pulse_B             <= (state_nxt == FIRE) && in_window(t_nxt, dly_b_nxt);
      busy                   <= (state_nxt != IDLE);
      done                   <= (state_nxt == DONE);
      overflow               <= ovf_nxt;
      fifo.write_en_fifo_A   <= (state_nxt == CAPTURE) && !fifo.fifo_A_full;
      fifo.write_en_fifo_B   <= (state_nxt == CAPTURE) && !fifo.fifo_B_full;
      fifo.write_data_fifo_A <= adc_A;
      fifo.write_data_fifo_B <= adc_B;
    end
  end

endmodule

// File: tb/tb_tx_fire_capture.sv
// Bench for tx_fire_capture: timeline model of each scan line checked every cycle, plus
// hand-computed pulse/write/done offsets for directed scenarios.
module tb_tx_fire_capture;
  localparam int DEPTH = 16, PTR_LEN = 4, WIDTH = 3, SCAN_LINES = 2;
  localparam int DELAY_W = 4, PULSE_LEN = 4, BLANK_CYCLES = 3;
`ifdef CAPTURE_BLANK_EN
  localparam int BLK = BLANK_CYCLES;
`else
  localparam int BLK = 0;
`endif

  logic               Clk = 1'b0;
  logic               reset, start;
  logic [DELAY_W-1:0] delay_A, delay_B;
  logic [WIDTH-1:0]   adc_A = '0, adc_B = '0;
  logic [PTR_LEN-1:0] scan_line;
  logic               tx_pulse_A, tx_pulse_B, busy, done, overflow;

  tx_fire_capture_if #(.WIDTH(WIDTH)) fif ();

  tx_fire_capture #(
    .DEPTH(DEPTH), .PTR_LEN(PTR_LEN), .WIDTH(WIDTH), .SCAN_LINES(SCAN_LINES),
    .DELAY_W(DELAY_W), .PULSE_LEN(PULSE_LEN), .BLANK_CYCLES(BLANK_CYCLES)
  ) dut (
    .Clk(Clk), .reset(reset), .start(start), .delay_A(delay_A), .delay_B(delay_B),
    .adc_A(adc_A), .adc_B(adc_B), .scan_line(scan_line), .tx_pulse_A(tx_pulse_A),
    .tx_pulse_B(tx_pulse_B), .busy(busy), .done(done), .overflow(overflow), .fifo(fif)
  );

  initial forever #5 Clk = ~Clk;

  int n_checks = 0, n_fail = 0;
  int ecnt = 0;
  logic               s_rst, s_start, s_fa, s_fb;
  logic [DELAY_W-1:0] s_dA, s_dB;
  logic [WIDTH-1:0]   s_adcA, s_adcB;

  int riseA_q[$], riseB_q[$], weA_rise_q[$], done_q[$];
  int wrA_cnt = 0, wrB_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, ecnt);
    end
  endtask

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Snapshot of everything the DUT sees at each rising edge.
  always @(posedge Clk) begin
    ecnt    <= ecnt + 1;
    s_rst   <= reset;
    s_start <= start;
    s_dA    <= delay_A;
    s_dB    <= delay_B;
    s_adcA  <= adc_A;
    s_adcB  <= adc_B;
    s_fa    <= fif.fifo_A_full;
    s_fb    <= fif.fifo_B_full;
  end

  initial forever begin
    @(posedge Clk); #2;
    adc_A = adc_A + 3'd1;
    adc_B = adc_B + 3'd3;
  end

  // Timeline model: a line is FIRE(max(dA,dB)+PULSE_LEN) + BLANK + CAPTURE(DEPTH) + NEXT(1).
  initial begin : compare
    bit active, ended, cap, prevA, prevB, prevW;
    bit e_busy, e_done, e_txa, e_txb, e_wea, e_web, movf;
    int k, cap0, line_len, ls, mline, mdA, mdB;
    active = 0; movf = 0; mline = 0; ls = 0; mdA = 0; mdB = 0;
    prevA = 0; prevB = 0; prevW = 0;
    forever begin
      @(negedge Clk);
      ended = 0;
      if (!reset || !s_rst) begin
        active = 0; mline = 0; movf = 0;
      end else begin
        if (active) begin
          k = ecnt - ls;
          cap0 = imax(mdA, mdB) + PULSE_LEN + BLK;
          line_len = cap0 + DEPTH + 1;
          if (k == line_len && mline != SCAN_LINES - 1) begin
            ls = ecnt; mline++; mdA = int'(s_dA); mdB = int'(s_dB);
          end else if (k == line_len + 1) begin
            active = 0; ended = 1;
          end
        end
        if (!active && !ended && s_start) begin
          active = 1; ls = ecnt; mline = 0; movf = 0; mdA = int'(s_dA); mdB = int'(s_dB);
        end
      end
      e_busy = 0; e_done = 0; e_txa = 0; e_txb = 0; e_wea = 0; e_web = 0;
      if (active) begin
        k = ecnt - ls;
        cap0 = imax(mdA, mdB) + PULSE_LEN + BLK;
        line_len = cap0 + DEPTH + 1;
        cap = (k >= cap0) && (k < cap0 + DEPTH);
        e_busy = 1;
        e_done = (k == line_len);
        e_txa = (k >= mdA) && (k < mdA + PULSE_LEN);
        e_txb = (k >= mdB) && (k < mdB + PULSE_LEN);
        e_wea = cap && !s_fa;
        e_web = cap && !s_fb;
        if (cap && (s_fa || s_fb)) movf = 1;
      end
      check("busy", 32'(busy), 32'(e_busy));
      check("done", 32'(done), 32'(e_done));
      check("tx_A", 32'(tx_pulse_A), 32'(e_txa));
      check("tx_B", 32'(tx_pulse_B), 32'(e_txb));
      check("we_A", 32'(fif.write_en_fifo_A), 32'(e_wea));
      check("we_B", 32'(fif.write_en_fifo_B), 32'(e_web));
      check("scan_line", 32'(scan_line), 32'(mline));
      check("overflow", 32'(overflow), 32'(movf));
      if (e_wea) check("wdata_A", 32'(fif.write_data_fifo_A), 32'(s_adcA));
      if (e_web) check("wdata_B", 32'(fif.write_data_fifo_B), 32'(s_adcB));
      if (tx_pulse_A && !prevA) riseA_q.push_back(ecnt);
      if (tx_pulse_B && !prevB) riseB_q.push_back(ecnt);
      if (fif.write_en_fifo_A && !prevW) weA_rise_q.push_back(ecnt);
      if (done) done_q.push_back(ecnt);
      wrA_cnt += int'(fif.write_en_fifo_A);
      wrB_cnt += int'(fif.write_en_fifo_B);
      prevA = tx_pulse_A; prevB = tx_pulse_B; prevW = fif.write_en_fifo_A;
    end
  end

  task automatic step();
    @(posedge Clk); #2;
  endtask

  task automatic pulse_start(output int s);
    start = 1'b1;
    step();
    start = 1'b0;
    s = ecnt;
  endtask

  task automatic wait_done(input int n0, input int budget, input string name);
    int i = 0;
    while (done_q.size() == n0 && i < budget) begin
      step();
      i++;
    end
    check({name, "_done_seen"}, 32'(done_q.size() > n0), 32'd1);
  endtask

  initial begin
    int s, ra, rb, wr, dn, wa, wb;
    reset = 1'b0; start = 1'b0; delay_A = '0; delay_B = '0;
    fif.fifo_A_full = 1'b0; fif.fifo_B_full = 1'b0;
    repeat (3) step();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_we_A", 32'(fif.write_en_fifo_A), 32'd0);
    check("rst_scan_line", 32'(scan_line), 32'd0);
    reset = 1'b1;
    step();

    // Two scan lines, dA=2 dB=5, FIFOs never full.
    delay_A = 4'd2; delay_B = 4'd5;
    ra = riseA_q.size(); rb = riseB_q.size(); wr = weA_rise_q.size();
    dn = done_q.size(); wa = wrA_cnt; wb = wrB_cnt;
    pulse_start(s);
    wait_done(dn, 200, "s2");
    check("s2_riseA_off", riseA_q[ra] - s, 2);
    check("s2_riseB_off", riseB_q[rb] - s, 5);
    check("s2_first_write", weA_rise_q[wr] - s, 9 + BLK);
    check("s2_riseA_line1", riseA_q[ra + 1] - s, 28 + BLK);
    check("s2_done_off", done_q[dn] - s, 52 + 2 * BLK);
    check("s2_writes_A", wrA_cnt - wa, 32);
    check("s2_writes_B", wrB_cnt - wb, 32);
    check("s2_scan_line", 32'(scan_line), 32'd1);
    repeat (3) step();
    check("s2_idle_busy", 32'(busy), 32'd0);

    // FIFO_B full for three capture cycles on the first line.
    dn = done_q.size(); wa = wrA_cnt; wb = wrB_cnt;
    pulse_start(s);
    while (ecnt < s + 11 + BLK) step();
    fif.fifo_B_full = 1'b1;
    repeat (3) step();
    fif.fifo_B_full = 1'b0;
    wait_done(dn, 200, "s4");
    check("s4_done_off", done_q[dn] - s, 52 + 2 * BLK);
    check("s4_writes_A", wrA_cnt - wa, 32);
    check("s4_writes_B", wrB_cnt - wb, 29);
    repeat (4) step();
    check("s4_overflow_sticky", 32'(overflow), 32'd1);

    // Zero delays, stray starts while busy, delay change mid-line applies to line 1 only.
    delay_A = 4'd0; delay_B = 4'd0;
    ra = riseA_q.size(); rb = riseB_q.size(); dn = done_q.size(); wa = wrA_cnt; wb = wrB_cnt;
    pulse_start(s);
    while (ecnt < s + 3) step();
    start = 1'b1; step(); start = 1'b0;
    while (ecnt < s + 10) step();
    delay_A = 4'd1; delay_B = 4'd3;
    while (ecnt < s + 30) step();
    start = 1'b1; step(); start = 1'b0;
    wait_done(dn, 200, "s5");
    check("s5_riseA_off", riseA_q[ra] - s, 0);
    check("s5_riseB_off", riseB_q[rb] - s, 0);
    check("s5_riseA_line1", riseA_q[ra + 1] - s, 22 + BLK);
    check("s5_riseB_line1", riseB_q[rb + 1] - s, 24 + BLK);
    check("s5_done_off", done_q[dn] - s, 45 + 2 * BLK);
    check("s5_writes_A", wrA_cnt - wa, 32);
    check("s5_overflow_cleared", 32'(overflow), 32'd0);
    repeat (4) step();
    check("s5_single_done", done_q.size() - dn, 1);

    // Asynchronous reset in the middle of capture, then a full run afterwards.
    delay_A = 4'd1; delay_B = 4'd1;
    pulse_start(s);
    while (ecnt < s + 10) step();
    check("s1_pre_we_A", 32'(fif.write_en_fifo_A), 32'd1);
    reset = 1'b0;
    #1;
    check("s1_async_we_A", 32'(fif.write_en_fifo_A), 32'd0);
    check("s1_async_we_B", 32'(fif.write_en_fifo_B), 32'd0);
    check("s1_async_busy", 32'(busy), 32'd0);
    check("s1_async_scan", 32'(scan_line), 32'd0);
    repeat (3) step();
    reset = 1'b1;
    step();
    delay_A = 4'd3; delay_B = 4'd0;
    dn = done_q.size(); wa = wrA_cnt; wb = wrB_cnt;
    pulse_start(s);
    wait_done(dn, 200, "s1");
    check("s1_done_off", done_q[dn] - s, 48 + 2 * BLK);
    check("s1_writes_B", wrB_cnt - wb, 32);
    repeat (3) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
